mu_step_fetch: RTL and testbench

Responder side of the micro-unit step handshake. The 2-bit step counter presents a step index. This block accepts the index and reads the corresponding microword from a 4-entry table. It delivers the microword downstream over a valid/ready handshake, then returns a one-cycle `End` pulse that lets the counter advance. It also reports `Last` when the sequence terminates, so the counter can fall back to its start value.

---
 rtl/mu_pkg.sv | 14 +
 rtl/mu_word_table.sv | 58 +++++
 rtl/mu_step_fetch.sv | 75 +++++++
 tb/tb_mu_step_fetch.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mu_pkg.sv
// mu_pkg: shared FSM state type, step sizing and microword init image for mu_step_fetch.
package mu_pkg;

    typedef enum logic [1:0] {IDLE, READ, PRESENT, DONE} mu_fetch_state_t;

    localparam int MU_STEP_W = 2;
    localparam int MU_STEPS  = 4;

    localparam logic [7:0] MU_ROM_INIT0 = 8'h11;
    localparam logic [7:0] MU_ROM_INIT1 = 8'h22;
    localparam logic [7:0] MU_ROM_INIT2 = 8'hA3;
    localparam logic [7:0] MU_ROM_INIT3 = 8'h44;

endpackage

// File: rtl/mu_word_table.sv
// mu_word_table: 4-entry microword store with reset init and registered read.
// The write port exists only when MU_FETCH_LOAD_EN is defined; otherwise the table is constant.
module mu_word_table
    import mu_pkg::*;
#(
    parameter int WORD_W = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 rd_en_i,
    input  logic [MU_STEP_W-1:0] rd_addr_i,
`ifdef MU_FETCH_LOAD_EN
    input  logic                 we_i,
    input  logic [MU_STEP_W-1:0] wr_addr_i,
    input  logic [WORD_W-1:0]    wr_data_i,
`endif
    output logic [WORD_W-1:0]    rd_data_o
);

    localparam int LOW_W = WORD_W - 1;

    // The MSB (last flag) always comes from bit 7; the remaining bits are resized to fit.
    function automatic logic [WORD_W-1:0] adapt(input logic [7:0] c);
        logic [LOW_W-1:0] low;
        low = LOW_W'(c[6:0]);
        return {c[7], low};
    endfunction

    localparam logic [WORD_W-1:0] INIT [MU_STEPS] = '{
        adapt(MU_ROM_INIT0), adapt(MU_ROM_INIT1), adapt(MU_ROM_INIT2), adapt(MU_ROM_INIT3)
    };

    logic [WORD_W-1:0] rd_word;
    logic [WORD_W-1:0] rd_data_q;

`ifdef MU_FETCH_LOAD_EN
    logic [WORD_W-1:0] mem_q [MU_STEPS];

    // Reset restores the init image and wins over a coincident load; loads land in any state
    always_ff @(posedge clk_i) begin
        if (rst_i) mem_q <= INIT;
        else if (we_i) mem_q[wr_addr_i] <= wr_data_i;
    end

    assign rd_word = mem_q[rd_addr_i];
`else
    assign rd_word = INIT[rd_addr_i];
`endif

    // Registered read; the output only moves on a read, so later loads never disturb a held word
    always_ff @(posedge clk_i) begin
        if (rst_i) rd_data_q <= '0;
        else if (rd_en_i) rd_data_q <= rd_word;
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/mu_step_fetch.sv
// mu_step_fetch: accepts a step index, fetches its microword, hands it downstream, then pulses end/last.
// Optional table load port enabled by defining MU_FETCH_LOAD_EN.
module mu_step_fetch
    import mu_pkg::*;
#(
    parameter int WORD_W = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [MU_STEP_W-1:0] step_i,
    input  logic                 step_valid_i,
    output logic                 step_ready_o,
    output logic [WORD_W-1:0]    word_o,
    output logic                 word_valid_o,
    input  logic                 word_ready_i,
`ifdef MU_FETCH_LOAD_EN
    input  logic                 load_en_i,
    input  logic [MU_STEP_W-1:0] load_addr_i,
    input  logic [WORD_W-1:0]    load_data_i,
`endif
    output logic                 end_o,
    output logic                 last_o
);

    mu_fetch_state_t      state_q, state_d;
    logic [MU_STEP_W-1:0] step_q, step_d;

    mu_word_table #(.WORD_W(WORD_W)) u_table (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .rd_en_i   (state_q == READ),
        .rd_addr_i (step_q),
`ifdef MU_FETCH_LOAD_EN
        .we_i      (load_en_i),
        .wr_addr_i (load_addr_i),
        .wr_data_i (load_data_i),
`endif
        .rd_data_o (word_o)
    );

    // State register and latched step index; reset aborts any in-flight step
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            step_q  <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
        end
    end

    // Next state: a step is only taken in IDLE, the word waits in PRESENT for downstream
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        case (state_q)
            IDLE: if (step_valid_i) begin
                state_d = READ;
                step_d  = step_i;
            end
            READ:    state_d = PRESENT;
            PRESENT: if (word_ready_i) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode the registered state only, so end/last are glitch-free single-cycle pulses
    always_comb begin
        step_ready_o = state_q == IDLE;
        word_valid_o = state_q == PRESENT;
        end_o        = state_q == DONE;
        last_o       = (state_q == DONE) && (word_o[WORD_W-1] || step_q == '1);
    end

endmodule

// File: tb/tb_mu_step_fetch.sv
// tb_mu_step_fetch: directed vector table, multi-cycle corner sequences and random steps vs a table model.
module tb_mu_step_fetch;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [1:0]   step = '0;
    logic         step_valid = 1'b0;
    logic         step_ready;
    logic [W-1:0] word;
    logic         word_valid;
    logic         word_ready = 1'b1;
    logic         end_p;
    logic         last;
`ifdef MU_FETCH_LOAD_EN
    logic         load_en = 1'b0;
    logic [1:0]   load_addr = '0;
    logic [W-1:0] load_data = '0;
`endif

    int n_checks = 0;
    int n_fail = 0;

    logic [W-1:0] model [4];

    typedef struct {
        logic [1:0]   s;
        int           stalls;
        bit           hold;
        logic [W-1:0] exp_word;
        bit           exp_last;
    } vec_t;

    vec_t vecs [6];

    always #5 clk = ~clk;

    mu_step_fetch #(.WORD_W(W)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .step_i       (step),
        .step_valid_i (step_valid),
        .step_ready_o (step_ready),
        .word_o       (word),
        .word_valid_o (word_valid),
        .word_ready_i (word_ready),
`ifdef MU_FETCH_LOAD_EN
        .load_en_i    (load_en),
        .load_addr_i  (load_addr),
        .load_data_i  (load_data),
`endif
        .end_o        (end_p),
        .last_o       (last)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        model = '{8'h11, 8'h22, 8'hA3, 8'h44};
    endfunction

    function automatic bit exp_last(input logic [1:0] s);
        return model[s][W-1] || (s == 2'd3);
    endfunction

    // Called at a falling edge while the DUT is idle; returns at the falling edge of the next idle cycle.
    task automatic run_step(input logic [1:0] s, input int stalls, input bit hold,
                            input logic [W-1:0] ew, input bit el);
        check("idle_ready", step_ready, 1);
        check("idle_end", end_p, 0);
        step = s;
        step_valid = 1'b1;
        word_ready = 1'b1;
        @(negedge clk);
        check("read_valid", word_valid, 0);
        check("read_ready", step_ready, 0);
        if (!hold) begin
            step_valid = 1'b0;
            step = 'x;
        end
        @(negedge clk);
        for (int k = 0; k <= stalls; k++) begin
            check("present_valid", word_valid, 1);
            check("present_word", word, ew);
            check("present_end", end_p, 0);
            word_ready = (k == stalls);
            @(negedge clk);
        end
        check("done_end", end_p, 1);
        check("done_last", last, el);
        check("done_valid", word_valid, 0);
        check("done_ready", step_ready, 0);
        word_ready = 1'b1;
        @(negedge clk);
        check("after_end", end_p, 0);
        check("after_last", last, 0);
        check("after_ready", step_ready, 1);
    endtask

    initial begin
        vecs = '{
            '{2'd0, 0, 1'b1, 8'h11, 1'b0},
            '{2'd2, 0, 1'b1, 8'hA3, 1'b1},
            '{2'd3, 0, 1'b1, 8'h44, 1'b1},
            '{2'd1, 0, 1'b0, 8'h22, 1'b0},
            '{2'd1, 5, 1'b0, 8'h22, 1'b0},
            '{2'd3, 2, 1'b0, 8'h44, 1'b1}
        };
        model_reset();

        repeat (2) @(negedge clk);
        check("rst_ready", step_ready, 1);
        check("rst_word", word, 0);
        check("rst_valid", word_valid, 0);
        check("rst_end", end_p, 0);
        check("rst_last", last, 0);
        rst = 1'b0;

        foreach (vecs[i]) run_step(vecs[i].s, vecs[i].stalls, vecs[i].hold, vecs[i].exp_word, vecs[i].exp_last);

        // Reset in PRESENT aborts the step, clears outputs and restores the table
`ifdef MU_FETCH_LOAD_EN
        load_en = 1'b1;
        load_addr = 2'd0;
        load_data = 8'hE7;
        @(negedge clk);
        load_en = 1'b0;
`endif
        step = 2'd2;
        step_valid = 1'b1;
        word_ready = 1'b0;
        @(negedge clk);
        step_valid = 1'b0;
        @(negedge clk);
        check("abort_pre_word", word, 8'hA3);
        check("abort_pre_valid", word_valid, 1);
        rst = 1'b1;
`ifdef MU_FETCH_LOAD_EN
        load_en = 1'b1;
        load_addr = 2'd0;
        load_data = 8'h55;
`endif
        @(negedge clk);
        check("abort_ready", step_ready, 1);
        check("abort_word", word, 0);
        check("abort_valid", word_valid, 0);
        check("abort_end", end_p, 0);
        check("abort_last", last, 0);
        rst = 1'b0;
        word_ready = 1'b1;
`ifdef MU_FETCH_LOAD_EN
        load_en = 1'b0;
`endif
        repeat (3) begin
            @(negedge clk);
            check("abort_no_end", end_p, 0);
            check("abort_idle", step_ready, 1);
        end
        model_reset();
        run_step(2'd0, 0, 1'b0, 8'h11, 1'b0);

`ifdef MU_FETCH_LOAD_EN
        load_en = 1'b1;
        load_addr = 2'd1;
        load_data = 8'h9C;
        @(negedge clk);
        load_en = 1'b0;
        model[1] = 8'h9C;
        run_step(2'd1, 0, 1'b0, 8'h9C, 1'b1);

        // Load into the entry being read in READ returns the old word; load in PRESENT leaves it held
        step = 2'd1;
        step_valid = 1'b1;
        word_ready = 1'b0;
        @(negedge clk);
        step_valid = 1'b0;
        load_en = 1'b1;
        load_addr = 2'd1;
        load_data = 8'h3A;
        @(negedge clk);
        check("rw_old_word", word, 8'h9C);
        load_data = 8'h77;
        @(negedge clk);
        load_en = 1'b0;
        check("present_load_word", word, 8'h9C);
        check("present_load_valid", word_valid, 1);
        word_ready = 1'b1;
        @(negedge clk);
        check("rw_end", end_p, 1);
        check("rw_last", last, 1);
        @(negedge clk);
        model[1] = 8'h77;
        run_step(2'd1, 0, 1'b0, model[1], exp_last(2'd1));
`endif

        for (int i = 0; i < 40; i++) begin
            logic [1:0] s;
            int         st;
            bit         h;
            s = 2'($urandom_range(0, 3));
            st = $urandom_range(0, 3);
            h = 1'($urandom_range(0, 1));
`ifdef MU_FETCH_LOAD_EN
            if ($urandom_range(0, 1) == 1) begin
                logic [1:0]   la;
                logic [W-1:0] ld;
                la = 2'($urandom_range(0, 3));
                ld = W'($urandom);
                step_valid = 1'b0;
                load_en = 1'b1;
                load_addr = la;
                load_data = ld;
                @(negedge clk);
                load_en = 1'b0;
                model[la] = ld;
            end
`endif
            run_step(s, st, h, model[s], exp_last(s));
        end
        step_valid = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
